// File: rtl/inverse_diffusion_stream_if.sv
// Stream bundle for the inverse-diffusion stage: ciphertext in, key in,
// tagged diffused-domain pixel out. slave = stage side, master = env side.
interface inverse_diffusion_stream_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_pixel;
  logic       k_valid;
  logic       k_ready;
  logic [7:0] k_byte;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_pixel;
  logic [7:0] m_row;
  logic [7:0] m_col;
  logic       m_last;
  logic       frame_done;

  modport slave (
    input  s_valid, s_pixel, k_valid, k_byte, m_ready,
    output s_ready, k_ready, m_valid, m_pixel, m_row, m_col,
    output m_last, frame_done
  );

  modport master (
    output s_valid, s_pixel, k_valid, k_byte, m_ready,
    input  s_ready, k_ready, m_valid, m_pixel, m_row, m_col,
    input  m_last, frame_done
  );
endinterface

// File: rtl/inverse_diffusion_stream.sv
// Inverse diffusion: P = ((C - K) mod 256) ^ C_prev, one pixel per cycle.
// Ports: clk, rst (sync, active high), bus (slave: s_*, k_*, m_*, frame_done).
module inverse_diffusion_stream #(
  parameter int         IMG_W = 256,
  parameter int         IMG_H = 256,
  parameter logic [7:0] IV    = 8'hA5
) (
  input logic                        clk,
  input logic                        rst,
  inverse_diffusion_stream_if.slave  bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    cprev_q, cprev_d;
  logic [7:0]    pix_q, pix_d;
  logic [7:0]    mrow_q, mrow_d;
  logic [7:0]    mcol_q, mcol_d;
  logic          mvalid_q, mvalid_d;
  logic          mlast_q, mlast_d;

  logic out_free;
  logic xfer;
  logic last_col;
  logic last_row;
  logic last_px;

  // Join: one pixel and one key byte move together, only when the
  // output register can take the result this cycle.
  assign out_free    = !mvalid_q | bus.m_ready;
  assign bus.s_ready = !rst & out_free & bus.k_valid;
  assign bus.k_ready = !rst & out_free & bus.s_valid;
  assign xfer        = !rst & out_free & bus.s_valid & bus.k_valid;

  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_row = (row_q == RW'(IMG_H - 1));
  assign last_px  = last_col & last_row;

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    cprev_d  = cprev_q;
    pix_d    = pix_q;
    mrow_d   = mrow_q;
    mcol_d   = mcol_q;
    mvalid_d = mvalid_q;
    mlast_d  = mlast_q;
    if (xfer) begin
      pix_d    = (bus.s_pixel - bus.k_byte) ^ cprev_q;
      mrow_d   = 8'(row_q);
      mcol_d   = 8'(col_q);
      mlast_d  = last_px;
      mvalid_d = 1'b1;
      // Chain on raw ciphertext; reseed so next frame starts from IV.
      cprev_d  = last_px ? IV : bus.s_pixel;
      col_d    = last_col ? '0 : col_q + 1'b1;
      if (last_col)
        row_d  = last_row ? '0 : row_q + 1'b1;
    end else if (bus.m_ready) begin
      mvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      cprev_q  <= IV;
      pix_q    <= '0;
      mrow_q   <= '0;
      mcol_q   <= '0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      cprev_q  <= cprev_d;
      pix_q    <= pix_d;
      mrow_q   <= mrow_d;
      mcol_q   <= mcol_d;
      mvalid_q <= mvalid_d;
      mlast_q  <= mlast_d;
    end
  end

  assign bus.m_valid    = mvalid_q;
  assign bus.m_pixel    = pix_q;
  assign bus.m_row      = mrow_q;
  assign bus.m_col      = mcol_q;
  assign bus.m_last     = mlast_q;
  // Fires only on the completing handshake of the held last pixel.
  assign bus.frame_done = mvalid_q & bus.m_ready & mlast_q;

endmodule

// File: tb/tb_inverse_diffusion_stream.sv
// Randomized bench for inverse_diffusion_stream with a frame-position model.
// Drives the master side of the bus interface; checks every cycle.
module tb_inverse_diffusion_stream;

  localparam int         W    = 256;
  localparam int         H    = 256;
  localparam int         NPIX = W * H;
  localparam logic [7:0] IV   = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inverse_diffusion_stream_if bus ();

  inverse_diffusion_stream #(
    .IMG_W (W),
    .IMG_H (H),
    .IV    (IV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: linear frame position and previous ciphertext.
  int         pos_m;
  logic [7:0] cprev_m;
  logic       mv_m;
  logic [7:0] ep;
  logic [7:0] er;
  logic [7:0] ec;
  logic       el;
  int         frames_m;
  int         frames_seen;

  task automatic chk_eq(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp,
               $time);
    end
  endtask

  task automatic model_reset();
    pos_m   = 0;
    cprev_m = IV;
    mv_m    = 1'b0;
    ep      = 8'h00;
    er      = 8'h00;
    ec      = 8'h00;
    el      = 1'b0;
  endtask

  // One clock: check handshake at negedge, update model, check outputs.
  task automatic step();
    logic xf;
    logic fd;
    @(negedge clk);
    xf = bus.s_valid & bus.k_valid & (!mv_m | bus.m_ready);
    chk_eq("s_ready", bus.s_ready, (!mv_m | bus.m_ready) & bus.k_valid);
    chk_eq("k_ready", bus.k_ready, (!mv_m | bus.m_ready) & bus.s_valid);
    fd = mv_m & bus.m_ready & el;
    chk_eq("frame_done", bus.frame_done, fd);
    if (fd) frames_seen++;
    @(posedge clk);
    if (xf) begin
      ep      = (bus.s_pixel - bus.k_byte) ^ cprev_m;
      er      = 8'(pos_m / W);
      ec      = 8'(pos_m % W);
      el      = (pos_m == NPIX - 1);
      cprev_m = el ? IV : bus.s_pixel;
      pos_m   = (pos_m + 1) % NPIX;
      mv_m    = 1'b1;
      if (el) frames_m++;
    end else if (bus.m_ready) begin
      mv_m = 1'b0;
    end
    #1;
    chk_eq("m_valid", bus.m_valid, mv_m);
    if (mv_m) begin
      chk_eq("m_pixel", bus.m_pixel, ep);
      chk_eq("m_row", bus.m_row, er);
      chk_eq("m_col", bus.m_col, ec);
      chk_eq("m_last", bus.m_last, el);
    end
  endtask

  task automatic drive(input logic sv, input logic kv, input logic mr,
                       input logic [7:0] c, input logic [7:0] k);
    bus.s_valid = sv;
    bus.k_valid = kv;
    bus.m_ready = mr;
    bus.s_pixel = c;
    bus.k_byte  = k;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_s_ready", bus.s_ready, 1'b0);
    chk_eq("rst_k_ready", bus.k_ready, 1'b0);
    chk_eq("rst_m_valid", bus.m_valid, 1'b0);
    chk_eq("rst_m_pixel", bus.m_pixel, 8'h00);
    chk_eq("rst_m_row", bus.m_row, 8'h00);
    chk_eq("rst_m_col", bus.m_col, 8'h00);
    chk_eq("rst_m_last", bus.m_last, 1'b0);
    chk_eq("rst_frame_done", bus.frame_done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
  endtask

  task automatic rnd_step(input int pv, input int pk, input int pr);
    drive(($urandom % 100) < pv, ($urandom % 100) < pk,
          ($urandom % 100) < pr, 8'($urandom), 8'($urandom));
    step();
  endtask

  initial begin
    frames_m    = 0;
    frames_seen = 0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    do_reset();
    drive(1'b1, 1'b1, 1'b1, 8'h10, 8'h05);
    step();
    chk_eq("tp1_pix", bus.m_pixel, 8'hAE);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    step();

    do_reset();
    drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h01);
    step();
    chk_eq("tp2_p0", bus.m_pixel, 8'h5A);
    drive(1'b1, 1'b1, 1'b1, 8'h20, 8'h30);
    step();
    chk_eq("tp2_p1", bus.m_pixel, 8'hF0);
    chk_eq("tp2_col", bus.m_col, 8'h01);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    step();

    // Backpressure: pending output held for 5 cycles.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 8'h3C, 8'h11);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
      step();
    end

    // Key stream skew 1,0,0,1.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i % 4 == 0) || (i % 4 == 3), 1'b1,
            8'($urandom), 8'($urandom));
      step();
    end

    // Full frame plus a few pixels into the next one.
    do_reset();
    for (int i = 0; i < NPIX + 8; i++) begin
      drive(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
      step();
    end
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    step();
    chk_eq("frames_done_cnt", frames_seen, frames_m);

    // Reset mid-frame just after pixel (3,17) is accepted.
    do_reset();
    while (pos_m != 3 * W + 18) begin
      drive(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
      step();
    end
    chk_eq("pre_rst_valid", bus.m_valid, 1'b1);
    chk_eq("pre_rst_row", bus.m_row, 8'd3);
    chk_eq("pre_rst_col", bus.m_col, 8'd17);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("midrst_m_valid", bus.m_valid, 1'b0);
    rst = 1'b0;
    model_reset();
    drive(1'b1, 1'b1, 1'b1, 8'h77, 8'h22);
    step();
    chk_eq("post_rst_row", bus.m_row, 8'h00);
    chk_eq("post_rst_col", bus.m_col, 8'h00);
    chk_eq("post_rst_pix", bus.m_pixel, 8'h55 ^ IV);

    // Random valids and backpressure.
    for (int i = 0; i < 3000; i++) rnd_step(70, 60, 65);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    step();
    chk_eq("frames_done_total", frames_seen, frames_m);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inverse_diffusion_stream.md
Name: inverse_diffusion_stream

Overview:
- Streaming inverse-diffusion stage of the chaos image decryption path.
- Sits directly upstream of the inverse permutation stage.
- Consumes ciphertext pixels in raster order plus a chaotic key-byte stream.
- Undoes the chained diffusion one pixel per cycle and emits tagged diffused-domain pixels for frame buffering ahead of the inverse permutation.

Parameters:
- IMG_W, 256, pixels per row (power of two, 2..256)
- IMG_H, 256, rows per frame (power of two, 2..256)
- IV, 8'hA5, chaining seed used as C[-1] at each frame start

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- s_valid  in  1  ciphertext pixel valid
- s_ready  out  1  ciphertext pixel accepted when s_valid&s_ready
- s_pixel  in  8  ciphertext pixel C[k]
- k_valid  in  1  key byte valid
- k_ready  out  1  key byte consumed when k_valid&k_ready
- k_byte  in  8  chaotic key byte K[k]
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts output
- m_pixel  out  8  recovered pixel P[k]
- m_row  out  8  row index of m_pixel
- m_col  out  8  column index of m_pixel
- m_last  out  1  high with the final pixel of the frame (row IMG_H-1, col IMG_W-1)
- frame_done  out  1  one-cycle pulse on the cycle the last-pixel output handshake completes

Behaviour:
- Arithmetic: P[k] = ((C[k] - K[k]) mod 256) XOR C_prev, with 8-bit wrap subtraction. After each accepted pixel, C_prev <= C[k] (the raw ciphertext, not P).
- C_prev is loaded with IV on reset and again on the cycle after the last pixel of a frame is accepted.
- Join handshake:
  - out_free = !m_valid | m_ready.
  - s_ready = out_free & k_valid.
  - k_ready = out_free & s_valid.
  - A transfer occurs only when s_valid & k_valid & out_free, consuming exactly one pixel and one key byte together.
  - No combinational path exists from s_valid to s_ready or from k_valid to k_ready.
- Output register: single stage, 1-cycle latency from transfer to m_valid.
  - If m_ready is high while m_valid is high and a new transfer occurs in the same cycle, the register reloads and m_valid stays high. This gives full throughput of 1 pixel/cycle.
  - m_pixel, m_row, m_col and m_last hold stable while m_valid & !m_ready.
- Counters:
  - col counts 0..IMG_W-1 on each transfer and wraps to 0, incrementing row.
  - row counts 0..IMG_H-1 and wraps to 0 after the last pixel.
  - m_row/m_col carry the counter values sampled at transfer. Unused upper bits are 0 when IMG_W or IMG_H < 256.
- Frame wrap:
  - After the last pixel, the next transfer is pixel (0,0) of a new frame and uses IV as C_prev.
  - Frames may be back-to-back with no idle cycle.
- frame_done: asserts for one cycle, coincident with the cycle m_valid&m_ready&m_last completes. It must never assert twice for one frame.
- Reset values: m_valid=0, m_pixel=0, m_row=0, m_col=0, m_last=0, frame_done=0, s_ready=0, k_ready=0, counters=0, C_prev=IV.
- Reset mid-frame: the partial frame is abandoned and any held output is dropped (m_valid=0 the cycle after rst). The next accepted pixel is treated as (0,0) with IV chaining.
- Stall cases:
  - Key stream starved (k_valid=0): no pixel is consumed and state holds.
  - Pixel stream starved (s_valid=0): no key byte is consumed.

Test Plan:
- Reset then single pixel with C=8'h10, K=8'h05, m_ready=1 -> one cycle later m_valid=1, m_pixel=(8'h0B^8'hA5)=8'hAE, row=0, col=0. C_prev becomes 8'h10.
- Two pixels C=8'h00,8'h20 with K=8'h01,8'h30, m_ready=1 -> P0=8'hFF^8'hA5=8'h5A (wrap subtraction); P1=8'hF0^8'h00=8'hF0.
- Full 256x256 frame, random C/K, all valids high, m_ready=1 -> 65536 outputs on consecutive cycles matching the software model. m_last and frame_done occur only at (255,255). The next frame's first pixel uses IV.
- Backpressure: hold m_ready=0 for 5 cycles with a pending output -> m_valid and the output fields stay stable, s_ready=k_ready=0, and no pixel or key byte is lost when m_ready rises.
- Stream skew: k_valid toggles 1,0,0,1 while s_valid=1 -> transfers only on k_valid=1 cycles, and pixel/key pairing stays in lockstep with the model.
- Assert rst at pixel (3,17) with m_valid=1 -> the cycle after rst m_valid=0. After release, the first output is at row=0, col=0 with IV chaining.
